dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester controller in front of the word-wide data memory: the core load/store port and the debug/DMA port.
- The memory has an asynchronous read path and a synchronous, word-only write path.
- The block arbitrates between the requesters, sequences each access, and adds byte/halfword stores through an internal read-modify-write (RMW) sequence.
- Sits between the core LSU / debug loader and the data memory.

Parameters:
- AW, 32, width of requester and memory byte addresses.
- DW, 32, data width; fixed at 32 because the byte-enable logic assumes 4 lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core request; held high until c_gnt.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  AW  core byte address; bits [1:0] ignored.
- c_wdata  in  DW  core store data, already lane-aligned.
- c_be  in  4  core byte enables (write only).
- c_gnt  out  1  core grant pulse.
- c_rvalid  out  1  core completion pulse.
- c_rdata  out  DW  core read data.
- d_req, d_we, d_addr, d_wdata, d_be, d_gnt, d_rvalid, d_rdata: same roles for the debug/DMA port.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory byte address, word aligned.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory asynchronous read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = DBG (so the core wins the first tie).
- Reset asserted mid-operation aborts the access immediately. No mem_we is issued afterwards, and no rvalid is produced for the aborted access.
- FSM states: IDLE, ACCESS, RMW_WR.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - x_gnt pulses combinationally in the same cycle.
  - On that edge the block latches requester id, we, {addr[AW-1:2],2'b00}, wdata and be, then moves to ACCESS.
  - Requesters must keep req/we/addr/wdata/be stable while req is high and gnt is low.
- Arbitration (both requesting in IDLE): round-robin. The requester not named by last_grant wins; last_grant updates on every grant.
- ACCESS: mem_addr = latched address.
  - Read: rdata register captures mem_rdata; go to IDLE.
  - Write with be == 4'hF: mem_we = 1, mem_wdata = latched wdata; go to IDLE.
  - Write with be == 4'h0: no mem_we; go to IDLE (no-op, still acknowledged).
  - Write with partial be: merge register captures mem_rdata with enabled lanes replaced by wdata; go to RMW_WR.
- RMW_WR: mem_we = 1, mem_wdata = merge register, same address; go to IDLE.
- Completion: x_rvalid pulses one cycle, on the cycle after the final ACCESS/RMW_WR cycle, to the latched requester only.
  - Reads: x_rdata holds the read word, stable until that requester's next rvalid.
  - Writes: x_rdata is not updated.
- Latency from gnt cycle T: read and full/empty write complete with rvalid at T+2; partial write at T+3.
- A new grant may occur in the same IDLE cycle as an rvalid, giving one access per 2 cycles at sustained rate.
- Outside ACCESS/RMW_WR: mem_we = 0 and mem_addr/mem_wdata = 0.
- Same-address hazards cannot occur: only one access is ever in flight.

Optional Feature:
- Macro DMEM_ARB_CORE_PRIO_EN.
- Defined: fixed priority. The core always wins a simultaneous request, and last_grant is unused.
- Undefined: round-robin as specified above.
- Latencies are identical in both modes.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RMW_WR}
  - requester id enum {REQ_CORE, REQ_DBG}
  - constants BE_FULL = 4'hF and BE_NONE = 4'h0
- One natural sub-module, dmem_byte_merge: purely combinational, old word + new word + be -> merged word. It is reused by a future sub-word load aligner.

Test Plan:
1. Core read, addr 0x0000_0010, mem word 0xDEADBEEF: c_gnt at T, mem_addr 0x10 at T+1, c_rvalid at T+2 with c_rdata 0xDEADBEEF, d_rvalid stays 0.
2. Core SB, addr 0x0000_0021, be 4'b0010, wdata 0x0000_AB00, old word 0x11223344: single mem_we at T+2 with 0x1122AB44 to 0x20; c_rvalid at T+3.
3. Both request every cycle for 6 grants: grant order CORE, DBG, CORE, DBG, CORE, DBG. With DMEM_ARB_CORE_PRIO_EN defined: all 6 go to CORE while it keeps requesting.
4. Debug write with be 4'h0 to addr 0x40: no mem_we at any cycle, d_rvalid at T+2, memory word unchanged.
5. rst_n deasserted during RMW_WR of a partial store: mem_we drops immediately, memory word unchanged, all outputs 0, first post-reset tie grants CORE.
6. Back-to-back core reads to 0x0 and 0x4: second c_gnt coincides with first c_rvalid; rvalids at T+2 and T+4.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro used by the arbiter: DMEM_ARB_CORE_PRIO_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW_WR
  } state_t;

  typedef enum logic {
    REQ_CORE,
    REQ_DBG
  } req_id_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational lane merge: each enabled byte lane takes the new word,
// the others keep the old word.
module dmem_byte_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < DW / 8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a word-wide data memory with
// async read and sync word write; sub-word stores use read-modify-write.
// Define DMEM_ARB_CORE_PRIO_EN for fixed core priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [3:0]    c_be,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state;
  req_id_t       lat_id;
  req_id_t       grant_id;
  logic          grant_any;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [3:0]    lat_be;
  logic [DW-1:0] merge_q;
  logic [DW-1:0] merged;
`ifndef DMEM_ARB_CORE_PRIO_EN
  req_id_t       last_grant;
`endif

  always_comb begin
    grant_id = REQ_CORE;
`ifdef DMEM_ARB_CORE_PRIO_EN
    if (!c_req) grant_id = REQ_DBG;
`else
    if (c_req && d_req) grant_id = (last_grant == REQ_DBG) ? REQ_CORE : REQ_DBG;
    else if (!c_req)    grant_id = REQ_DBG;
`endif
  end

  // Grant is gated by rst_n so every output reads 0 while reset is held.
  assign grant_any = rst_n && (state == IDLE) && (c_req || d_req);
  assign c_gnt     = grant_any && (grant_id == REQ_CORE);
  assign d_gnt     = grant_any && (grant_id == REQ_DBG);
  assign busy      = (state != IDLE);

  dmem_byte_merge #(.DW(DW)) u_merge (
    .old_word (mem_rdata),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      ACCESS: begin
        mem_addr = lat_addr;
        if (lat_we && lat_be == BE_FULL) begin
          mem_we    = 1'b1;
          mem_wdata = lat_wdata;
        end
      end
      RMW_WR: begin
        mem_addr  = lat_addr;
        mem_we    = 1'b1;
        mem_wdata = merge_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_id     <= REQ_CORE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      merge_q    <= '0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
`ifndef DMEM_ARB_CORE_PRIO_EN
      last_grant <= REQ_DBG;
`endif
    end else begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            lat_id <= grant_id;
            if (grant_id == REQ_CORE) begin
              lat_we    <= c_we;
              lat_addr  <= c_addr & ~AW'(3);
              lat_wdata <= c_wdata;
              lat_be    <= c_be;
            end else begin
              lat_we    <= d_we;
              lat_addr  <= d_addr & ~AW'(3);
              lat_wdata <= d_wdata;
              lat_be    <= d_be;
            end
`ifndef DMEM_ARB_CORE_PRIO_EN
            last_grant <= grant_id;
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we && lat_be != BE_FULL && lat_be != BE_NONE) begin
            merge_q <= merged;
            state   <= RMW_WR;
          end else begin
            if (!lat_we) begin
              if (lat_id == REQ_CORE) c_rdata <= mem_rdata;
              else                    d_rdata <= mem_rdata;
            end
            c_rvalid <= (lat_id == REQ_CORE);
            d_rvalid <= (lat_id == REQ_DBG);
            state    <= IDLE;
          end
        end
        RMW_WR: begin
          c_rvalid <= (lat_id == REQ_CORE);
          d_rvalid <= (lat_id == REQ_DBG);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model
// scheduling expected per-cycle outputs, directed cases plus random traffic.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Expected events per future cycle, filled in when a grant is predicted.
  typedef struct packed {
    logic        acc, we, rvc, rvd, rd;
    logic [31:0] addr, wdata, rdata;
  } slot_t;

  slot_t       slots [8];
  logic [31:0] ref_mem [64];
  int          cyc = 0, free_cyc = 0;
  bit          last_dbg = 1'b1;
  logic [31:0] exp_crd = '0, exp_drd = '0;
  int          n_cmp = 0, n_fail = 0;

  logic        s_cgnt, s_dgnt, s_crv, s_drv, s_mwe, s_busy;
  logic [31:0] s_maddr, s_mwdata, s_crdata, s_drdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_rv(input int t, input bit core, input bit rd, input logic [31:0] data);
    if (core) slots[t % 8].rvc = 1'b1;
    else      slots[t % 8].rvd = 1'b1;
    slots[t % 8].rd    = rd;
    slots[t % 8].rdata = data;
  endtask

  task automatic issue(input bit core);
    logic        we;
    logic [31:0] a, wd, old, mask;
    logic [3:0]  be;
    int          t;
    t    = cyc;
    we   = core ? c_we : d_we;
    a    = (core ? c_addr : d_addr) & 32'hFFFF_FFFC;
    wd   = core ? c_wdata : d_wdata;
    be   = core ? c_be : d_be;
    old  = ref_mem[a[7:2]];
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    slots[(t + 1) % 8].acc  = 1'b1;
    slots[(t + 1) % 8].addr = a;
    if (!we) begin
      set_rv(t + 2, core, 1'b1, old);
      free_cyc = t + 2;
    end else if (be == 4'hF) begin
      slots[(t + 1) % 8].we    = 1'b1;
      slots[(t + 1) % 8].wdata = wd;
      set_rv(t + 2, core, 1'b0, '0);
      free_cyc = t + 2;
    end else if (be == 4'h0) begin
      set_rv(t + 2, core, 1'b0, '0);
      free_cyc = t + 2;
    end else begin
      slots[(t + 2) % 8].acc   = 1'b1;
      slots[(t + 2) % 8].we    = 1'b1;
      slots[(t + 2) % 8].addr  = a;
      slots[(t + 2) % 8].wdata = (old & ~mask) | (wd & mask);
      set_rv(t + 3, core, 1'b0, '0);
      free_cyc = t + 3;
    end
    last_dbg = !core;
  endtask

  // Sample at the falling edge, compare against the model, then advance
  // one clock and commit any observed memory write.
  task automatic tick_check();
    slot_t s;
    bit e_cg, e_dg, e_busy, core;
    logic pend_we;
    logic [31:0] pend_addr, pend_data;
    @(negedge clk);
    s_cgnt = c_gnt; s_dgnt = d_gnt; s_crv = c_rvalid; s_drv = d_rvalid;
    s_mwe = mem_we; s_busy = busy; s_maddr = mem_addr; s_mwdata = mem_wdata;
    s_crdata = c_rdata; s_drdata = d_rdata;
    s = slots[cyc % 8];
    slots[cyc % 8] = '0;
    e_cg = 1'b0; e_dg = 1'b0; e_busy = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) slots[i] = '0;
      s = '0; free_cyc = cyc; last_dbg = 1'b1; exp_crd = '0; exp_drd = '0;
    end else begin
      if (s.we) ref_mem[s.addr[7:2]] = s.wdata;
      if (s.rvc && s.rd) exp_crd = s.rdata;
      if (s.rvd && s.rd) exp_drd = s.rdata;
      e_busy = (cyc < free_cyc);
      if (!e_busy && (c_req || d_req)) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
        core = c_req;
`else
        core = c_req && (!d_req || last_dbg);
`endif
        e_cg = core; e_dg = !core;
        issue(core);
      end
    end
    chk("c_gnt", s_cgnt, e_cg);
    chk("d_gnt", s_dgnt, e_dg);
    chk("busy", s_busy, e_busy);
    chk("mem_we", s_mwe, s.we);
    chk("mem_addr", s_maddr, s.acc ? s.addr : 32'h0);
    if (s.we)        chk("mem_wdata", s_mwdata, s.wdata);
    else if (!s.acc) chk("mem_wdata_idle", s_mwdata, 32'h0);
    chk("c_rvalid", s_crv, s.rvc);
    chk("d_rvalid", s_drv, s.rvd);
    chk("c_rdata", s_crdata, exp_crd);
    chk("d_rdata", s_drdata, exp_drd);
    pend_we = s_mwe; pend_addr = s_maddr; pend_data = s_mwdata;
    @(posedge clk);
    cyc++;
    #1;
    if (pend_we) mem[pend_addr[7:2]] = pend_data;
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic set_c(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    c_req = rq; c_we = we; c_addr = a; c_wdata = wd; c_be = be;
  endtask

  task automatic set_d(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req = rq; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
  endtask

  function automatic logic [3:0] rand_be();
    case ($urandom_range(0, 3))
      0:       return 4'hF;
      1:       return 4'h0;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic drain();
    c_req = 1'b0; d_req = 1'b0;
    repeat (4) tick_check();
  endtask

  task automatic apply_reset();
    c_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick_check();
    rst_n = 1'b1;
  endtask

  int order [6];
  int ng;

  initial begin
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    // Requests held high during reset must not be granted.
    set_c(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_d(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    tick_check();
    chk("rst_c_gnt", s_cgnt, 0);
    chk("rst_busy", s_busy, 0);
    tick_check();
    c_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    tick_check();

    // Core read of 0x10.
    poke(4, 32'hDEADBEEF);
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick_check(); chk("t1_gnt", s_cgnt, 1);
    c_req = 1'b0;
    tick_check(); chk("t1_addr", s_maddr, 32'h10);
    tick_check(); chk("t1_rvalid", s_crv, 1); chk("t1_rdata", s_crdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", s_drv, 0);

    // Core byte store into lane 1 of 0x20.
    poke(8, 32'h11223344);
    set_c(1'b1, 1'b1, 32'h21, 32'h0000AB00, 4'b0010);
    tick_check(); chk("t2_gnt", s_cgnt, 1);
    c_req = 1'b0;
    tick_check(); chk("t2_no_we_access", s_mwe, 0);
    tick_check(); chk("t2_we", s_mwe, 1); chk("t2_waddr", s_maddr, 32'h20);
    chk("t2_wdata", s_mwdata, 32'h1122AB44);
    tick_check(); chk("t2_rvalid", s_crv, 1); chk("t2_mem", mem[8], 32'h1122AB44);
    drain();

    // Contention: six grants under continuous requests from both sides.
    apply_reset();
    set_c(1'b1, 1'b0, 32'($urandom_range(0, 255)), 32'h0, 4'h0);
    set_d(1'b1, 1'b0, 32'($urandom_range(0, 255)), 32'h0, 4'h0);
    ng = 0;
    for (int k = 0; k < 20 && ng < 6; k++) begin
      tick_check();
      if (s_cgnt) begin order[ng] = 0; ng++; c_addr = 32'($urandom_range(0, 255)); end
      else if (s_dgnt) begin order[ng] = 1; ng++; d_addr = 32'($urandom_range(0, 255)); end
    end
    chk("t3_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
      chk("t3_order", order[i], 0);
`else
      chk("t3_order", order[i], i % 2);
`endif
    end
    drain();

    // Debug write with no byte enables to 0x40.
    poke(16, 32'h0BADCAFE);
    set_d(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0);
    tick_check(); chk("t4_gnt", s_dgnt, 1);
    d_req = 1'b0;
    tick_check(); chk("t4_we1", s_mwe, 0);
    tick_check(); chk("t4_we2", s_mwe, 0); chk("t4_rvalid", s_drv, 1);
    tick_check(); chk("t4_mem", mem[16], 32'h0BADCAFE);

    // Reset during RMW_WR of a partial store to 0x44.
    poke(17, 32'hCAFEF00D);
    set_c(1'b1, 1'b1, 32'h44, 32'h55660000, 4'b1100);
    tick_check(); chk("t5_gnt", s_cgnt, 1);
    c_req = 1'b0;
    tick_check();
    rst_n = 1'b0;
    set_c(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    set_d(1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    tick_check(); chk("t5_we_abort", s_mwe, 0); chk("t5_busy", s_busy, 0);
    chk("t5_maddr", s_maddr, 0); chk("t5_c_rvalid", s_crv, 0);
    tick_check();
    rst_n = 1'b1;
    tick_check(); chk("t5_tie_core", s_cgnt, 1); chk("t5_tie_dbg", s_dgnt, 0);
    chk("t5_mem", mem[17], 32'hCAFEF00D);
    drain();

    // Back-to-back core reads of 0x0 and 0x4.
    poke(0, 32'hA5A5_0000);
    poke(1, 32'h5A5A_0004);
    set_c(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick_check(); chk("t6_gnt0", s_cgnt, 1);
    c_addr = 32'h4;
    tick_check(); chk("t6_wait", s_cgnt, 0);
    tick_check(); chk("t6_gnt1", s_cgnt, 1); chk("t6_rv0", s_crv, 1);
    chk("t6_rd0", s_crdata, 32'hA5A5_0000);
    c_req = 1'b0;
    tick_check();
    tick_check(); chk("t6_rv1", s_crv, 1); chk("t6_rd1", s_crdata, 32'h5A5A_0004);
    drain();

    // Random traffic on both ports.
    repeat (3000) begin
      if (s_cgnt || !c_req) begin
        if ($urandom_range(0, 2) != 0)
          set_c(1'b1, 1'($urandom), 32'($urandom_range(0, 255)), $urandom, rand_be());
        else c_req = 1'b0;
      end
      if (s_dgnt || !d_req) begin
        if ($urandom_range(0, 2) != 0)
          set_d(1'b1, 1'($urandom), 32'($urandom_range(0, 255)), $urandom, rand_be());
        else d_req = 1'b0;
      end
      tick_check();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
